// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low patterns {g,f,e,d,c,b,a}
// and the digit/segment types used by the encoder and the readback path.
package ssd_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_to_digit.sv
// Combinational segment-pattern to decimal-digit decoder.
// Ports: i_seg (active-low pattern), o_digit (0..9), o_legal (pattern is a digit).
module ssd_to_digit
    import ssd_pkg::*;
(
    input  seg_t   i_seg,
    output digit_t o_digit,
    output logic   o_legal
);

    always_comb begin
        o_digit = '0;
        o_legal = 1'b1;
        case (i_seg)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_readback.sv
// Recovers the digits shown on a multiplexed active-low 7-segment bus.
// Ports: clk, rst (async high), an (anode select, active-low), seg (pattern),
// digits_out (4 bits per position), err_mask (undecodable positions),
// frame_valid (one-cycle pulse when a full frame is published).
module ssd_readback
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  seg_t                    seg,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   r_an_q;
    seg_t                    r_seg_q;
    logic [CW-1:0]           r_cnt;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [NUM_DIGITS-1:0]   r_bad;
    logic [4*NUM_DIGITS-1:0] r_stage;
    logic                    r_done;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_err;
    logic                    r_fv;

    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_an_legal;
    logic                    w_same;
    logic [CW-1:0]           w_cnt_nx;
    logic                    w_capture;
    digit_t                  w_digit;
    logic                    w_seg_legal;
    logic [NUM_DIGITS-1:0]   w_seen_base;
    logic [NUM_DIGITS-1:0]   w_bad_base;
    logic [NUM_DIGITS-1:0]   w_seen_nx;
    logic [NUM_DIGITS-1:0]   w_bad_nx;
    logic [4*NUM_DIGITS-1:0] w_stage_nx;
    logic                    w_done_nx;

    ssd_to_digit u_dec (
        .i_seg   (seg),
        .o_digit (w_digit),
        .o_legal (w_seg_legal)
    );

    // Active-high select; legal when exactly one bit is set.
    always_comb begin
        w_sel      = ~an;
        w_an_legal = (w_sel != '0) &&
                     ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
        w_same     = (an == r_an_q) && (seg == r_seg_q);
    end

    // Dwell counter saturates so a long dwell strobes only once.
    always_comb begin
        w_cnt_nx = '0;
        if (w_an_legal) begin
            if (!w_same)
                w_cnt_nx = CW'(1);
            else if (r_cnt == CNT_MAX)
                w_cnt_nx = CNT_MAX;
            else
                w_cnt_nx = r_cnt + CW'(1);
        end
        w_capture = (w_cnt_nx == CNT_MAX) && (r_cnt != CNT_MAX);
    end

    // The frame is published on the edge after completion; that same
    // edge starts the next frame from empty masks.
    always_comb begin
        w_seen_base = r_done ? '0 : r_seen;
        w_bad_base  = r_done ? '0 : r_bad;
        w_seen_nx   = w_seen_base;
        w_bad_nx    = w_bad_base;
        w_stage_nx  = r_stage;
        if (w_capture) begin
            w_seen_nx = w_seen_base | w_sel;
            if (w_seg_legal)
                w_bad_nx = w_bad_base & ~w_sel;
            else
                w_bad_nx = w_bad_base | w_sel;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_sel[i] && w_seg_legal)
                    w_stage_nx[4*i +: 4] = w_digit;
            end
        end
        w_done_nx = w_capture && (&w_seen_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_q   <= '1;
            r_seg_q  <= '1;
            r_cnt    <= '0;
            r_seen   <= '0;
            r_bad    <= '0;
            r_stage  <= '0;
            r_done   <= 1'b0;
            r_digits <= '0;
            r_err    <= '0;
            r_fv     <= 1'b0;
        end else begin
            r_an_q  <= an;
            r_seg_q <= seg;
            r_cnt   <= w_cnt_nx;
            r_seen  <= w_seen_nx;
            r_bad   <= w_bad_nx;
            r_stage <= w_stage_nx;
            r_done  <= w_done_nx;
            r_fv    <= r_done;
            if (r_done) begin
                r_digits <= r_stage;
                r_err    <= r_bad;
            end
        end
    end

    assign digits_out  = r_digits;
    assign err_mask    = r_err;
    assign frame_valid = r_fv;

endmodule

// File: tb/tb_ssd_readback.sv
// Directed self-checking bench for ssd_readback and ssd_to_digit.
// Patterns below are hand-written active-low {g,f,e,d,c,b,a}.
module tb_ssd_readback;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an  = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] digits_out;
    logic [3:0]  err_mask;
    logic        frame_valid;

    logic [6:0]  dec_seg = '0;
    logic [3:0]  dec_digit;
    logic        dec_legal;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;
    int cap_cnt = 0;

    ssd_readback #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .digits_out  (digits_out),
        .err_mask    (err_mask),
        .frame_valid (frame_valid)
    );

    ssd_to_digit u_dec (
        .i_seg   (dec_seg),
        .o_digit (dec_digit),
        .o_legal (dec_legal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            fv_cyc = cyc;
        end
        if (dut.w_capture)
            cap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s,
                        input int n);
        an  = a;
        seg = s;
        step(n);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3,
                        input int n, output int st);
        hold(4'b1110, s0, n);
        hold(4'b1101, s1, n);
        hold(4'b1011, s2, n);
        st = cyc;
        hold(4'b0111, s3, n);
    endtask

    logic [6:0] tbl [10];
    int st;
    int legal_cnt;
    logic exp_legal;
    logic [3:0] exp_digit;

    initial begin
        tbl = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

        // Power-on reset
        step(2);
        check("rst_digits", digits_out, 0);
        check("rst_err", err_mask, 0);
        check("rst_fv", frame_valid, 0);
        rst = 1'b0;
        step(1);

        // Reset in mid-dwell discards the partial frame
        fv_cnt = 0;
        hold(4'b1110, S1, 6);
        hold(4'b1101, S2, 6);
        hold(4'b1011, S3, 2);
        rst = 1'b1;
        step(2);
        check("midrst_digits", digits_out, 0);
        check("midrst_err", err_mask, 0);
        check("midrst_fv", frame_valid, 0);
        rst = 1'b0;
        hold(4'b0111, S4, 6);
        hold(4'b1110, S5, 6);
        hold(4'b1101, S6, 6);
        check("midrst_nofv", fv_cnt, 0);
        hold(4'b1011, S7, 6);
        check("midrst_fv_cnt", fv_cnt, 1);
        check("midrst_digits2", digits_out, 16'h4765);
        hold(4'hF, SB, 3);

        // Nominal scan
        fv_cnt = 0;
        scan(S1, S2, S3, S4, 6, st);
        check("nom_digits", digits_out, 16'h4321);
        check("nom_err", err_mask, 0);
        check("nom_fv_cnt", fv_cnt, 1);
        check("nom_fv_time", fv_cyc, st + 5);
        check("nom_fv_low", frame_valid, 0);
        hold(4'hF, SB, 5);
        check("nom_hold", digits_out, 16'h4321);

        // Glitch: dwell too short, then blanked
        fv_cnt  = 0;
        cap_cnt = 0;
        hold(4'b1110, S7, 3);
        hold(4'b1110, S8, 1);
        hold(4'hF, SB, 3);
        check("glitch_cap", cap_cnt, 0);
        check("glitch_seen0", dut.r_seen[0], 0);
        check("glitch_fv", fv_cnt, 0);
        check("glitch_digits", digits_out, 16'h4321);

        // Illegal pattern keeps the last good value
        fv_cnt = 0;
        scan(S9, S8, S5, S0, 6, st);
        check("pre_digits", digits_out, 16'h0589);
        check("pre_err", err_mask, 0);
        hold(4'hF, SB, 3);
        fv_cnt = 0;
        scan(S1, S2, SB, S3, 6, st);
        check("bad_fv_cnt", fv_cnt, 1);
        check("bad_err", err_mask, 4'b0100);
        check("bad_pos2", digits_out[11:8], 5);
        check("bad_digits", digits_out, 16'h3521);
        hold(4'hF, SB, 3);

        // Illegal anode selects
        fv_cnt  = 0;
        cap_cnt = 0;
        hold(4'b1100, S1, 10);
        check("an2_cnt", dut.r_cnt, 0);
        hold(4'b1111, S1, 10);
        check("an0_cnt", dut.r_cnt, 0);
        check("ian_cap", cap_cnt, 0);
        check("ian_fv", fv_cnt, 0);
        check("ian_digits", digits_out, 16'h3521);
        check("ian_err", err_mask, 4'b0100);

        // Long dwell
        fv_cnt  = 0;
        cap_cnt = 0;
        scan(S6, S7, S8, S9, 20, st);
        check("long_cap", cap_cnt, 4);
        check("long_fv_cnt", fv_cnt, 1);
        check("long_digits", digits_out, 16'h9876);
        check("long_err", err_mask, 0);

        // Exhaustive decoder sweep
        legal_cnt = 0;
        for (int v = 0; v < 128; v++) begin
            dec_seg = 7'(v);
            #1;
            exp_legal = 1'b0;
            exp_digit = '0;
            for (int d = 0; d < 10; d++) begin
                if (tbl[d] == dec_seg) begin
                    exp_legal = 1'b1;
                    exp_digit = 4'(d);
                end
            end
            if (dec_legal)
                legal_cnt++;
            check("dec_legal", {dec_seg, dec_legal}, {dec_seg, exp_legal});
            if (exp_legal)
                check("dec_digit", {dec_seg, dec_digit}, {dec_seg, exp_digit});
        end
        check("dec_count", legal_cnt, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_readback.md
Name: ssd_readback

Overview:
- Reads back a multiplexed, active-low seven-segment display bus (anode select plus segment pattern) and recovers the decimal digit shown on each position.
- It is the decoding counterpart of the digit-to-segment encoder. It lets board-level self-test and benches confirm what the display scanner is actually driving.
- Captures a position only after its pattern has been stable for a programmable dwell. Publishes a full frame once every position has been captured.

Parameters:
- NUM_DIGITS, 4, number of display positions (anode lines); must be at least 1.
- STABLE_CYCLES, 4, consecutive identical samples required before a position is captured; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  NUM_DIGITS  anode select, active-low; a legal select has exactly one bit low.
- seg  input  7  segment pattern {g,f,e,d,c,b,a}, active-low.
- digits_out  output  4*NUM_DIGITS  recovered digits; position i occupies bits [4i+3:4i].
- err_mask  output  NUM_DIGITS  bit i set when position i showed an undecodable pattern in the last frame.
- frame_valid  output  1  one-cycle pulse when digits_out and err_mask update.

Behaviour:
- Reset, asynchronous, while rst=1:
  - digits_out=0, err_mask=0, frame_valid=0.
  - Staging digits cleared, seen/bad masks cleared, dwell count=0.
  - an_q and seg_q set to all ones.
  - A reset in mid-frame discards the partial frame.
- Every rising edge registers an into an_q and seg into seg_q.
- Dwell counter, width $clog2(STABLE_CYCLES+1):
  - Input an is legal (exactly one bit low), an==an_q and seg==seg_q: next_cnt = min(cnt+1, STABLE_CYCLES).
  - an is legal but the sample differs from an_q/seg_q: next_cnt=1.
  - an is all ones (blank) or has two or more bits low: next_cnt=0. Nothing is captured.
- Capture strobe = (next_cnt==STABLE_CYCLES) and (cnt!=STABLE_CYCLES).
  - Exactly one capture per dwell, however long the dwell lasts.
  - For an input held from before edge k, the capture occurs at edge k+STABLE_CYCLES-1.
- Capture for position i (index of the low an bit), using the raw seg:
  - Legal pattern: the staging slot is written, bad[i] is cleared and seen[i] is set.
  - Illegal pattern: the staging slot is kept, bad[i] is set and seen[i] is set.
  - If position i is re-captured within the same frame, the new result overwrites the old one.
- Decode table (any other pattern is illegal, including blank 1111111):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Frame completion happens when (seen | seen-update) is all ones after a capture, counting the completing capture itself. On the following edge:
  - digits_out <= staging, with the completing capture included.
  - err_mask <= bad, with the completing capture included.
  - frame_valid=1 for one cycle.
  - seen and bad are cleared. Staging is kept, so an errored slot in the next frame reports the last good value.
- Outputs hold their values between frames.
- Throughput: back-to-back frames are supported. A capture on the cycle that frame_valid is high counts toward the new frame.

Decomposition:
- Package ssd_pkg holds:
  - SEG_0..SEG_9 as 7-bit constants and SEG_BLANK=7'b1111111.
  - typedef digit_t (logic [3:0]) and typedef seg_t (logic [6:0]).
  - The encoder is expected to migrate to these same constants.
- Sub-module ssd_to_digit: a combinational decoder, seg_t in, digit_t plus a legal flag out. It is the exact inverse of the decode table and can be unit-tested on its own.
- The top level holds the sampling registers, dwell counter, staging and frame logic.

Test Plan:
- Reset: run a partial scan, assert rst for 2 cycles mid-dwell. Required: digits_out=0, err_mask=0, frame_valid=0, and no frame_valid until a complete new scan.
- Nominal scan: an=1110/1101/1011/0111 with seg=SEG_1/SEG_2/SEG_3/SEG_4, each held 6 cycles. Required: digits_out=16'h4321, err_mask=0, and frame_valid high exactly one cycle, one edge after the 4th capture.
- Glitch rejection: hold an=1110, seg=SEG_7 for 3 cycles, then change seg. Required: no capture for that dwell, seen[0] stays 0, no frame.
- Illegal pattern: complete a scan where position 2 shows 1111111, following a prior frame that had 5 there. Required: err_mask=4'b0100 and digits_out[11:8]=5.
- Illegal anode: an=1100 for 10 cycles, then an=1111 for 10 cycles. Required: dwell count 0, no capture, outputs unchanged.
- Long dwell and exhaustive decode: hold each position 20 cycles. Required: exactly one capture per position and one frame_valid. Sweep all 128 seg values through ssd_to_digit and check exactly 10 are legal, each mapping per the decode table.
